mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Initiator side of the data-memory port: accepts load/store requests from the CPU execute stage over a valid/ready handshake.
- Drives the memory's mem_read / mem_write / address / write_data pins and captures its combinational read_data.
- Returns one response per request.
- Supports LC-3 indirect accesses (LDI/STI) as a two-phase pointer-then-data sequence, plus an address bounds check.

Parameters:
- ADDR_W, 32, width of word address on request and memory sides
- DATA_W, 32, data word width
- MEM_DEPTH, 1024, number of words in the attached memory; word addresses >= MEM_DEPTH fault

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_op  in  2  00 LOAD, 01 STORE, 10 LOAD_IND, 11 STORE_IND
- req_addr  in  ADDR_W  word address (pointer location for *_IND)
- req_wdata  in  DATA_W  store data
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes response
- resp_data  out  DATA_W  load result; 0 for stores and faults
- resp_fault  out  1  address out of range
- mem_read  out  1  to memory read enable
- mem_write  out  1  to memory write enable
- mem_address  out  ADDR_W  to memory address
- mem_write_data  out  DATA_W  to memory write data
- mem_read_data  in  DATA_W  from memory (combinational)

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - req_ready=0 while rst_n=0, and 1 after release.
  - resp_valid=0, resp_data=0, resp_fault=0.
  - All mem_* outputs 0.
  - Latched op/addr/wdata/pointer cleared.
- States: IDLE, PTR, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch op/addr/wdata.
  - Next state is PTR for *_IND ops, otherwise ACCESS.
- PTR (one cycle):
  - If latched addr >= MEM_DEPTH: set fault, go to RESP with no memory activity.
  - Otherwise: mem_read=1, mem_address=addr; latch mem_read_data as pointer at cycle end; go to ACCESS with effective address = pointer.
- ACCESS (one cycle), effective address = addr (direct) or pointer (indirect):
  - If effective address >= MEM_DEPTH: fault, no mem_read/mem_write, go to RESP.
  - Load: mem_read=1; resp_data latched from mem_read_data at cycle end.
  - Store: mem_write=1, mem_write_data=wdata for exactly one cycle; the memory writes on the closing edge.
  - Then go to RESP.
- RESP:
  - resp_valid=1 with stable resp_data and resp_fault.
  - Hold until resp_ready=1, then IDLE.
  - resp_valid drops the cycle after the handshake; resp_data and resp_fault are cleared on leaving RESP.
- mem_* outputs are nonzero only in PTR or ACCESS; they are 0 in IDLE and RESP.
- Latency (accept edge to resp_valid high): direct 2 cycles; indirect 3 cycles; fault detected in PTR 2 cycles.
- Back-to-back: a new request can be accepted no earlier than the cycle after the RESP handshake.
  - Throughput is one direct op per 3 cycles with resp_ready tied high.
- Unsigned compare for bounds; no byte addressing, no alignment logic.
- Reset mid-operation:
  - mem_write deasserts immediately (combinational from state), so no write is committed.
  - Any in-flight response is discarded.
- req_op, req_addr and req_wdata are ignored outside IDLE.

Optional Feature:
- Macro MAU_INDIRECT_EN.
- Defined: *_IND ops behave as above.
- Undefined: PTR state and pointer register are not built. *_IND ops go directly to RESP with resp_fault=1, resp_data=0 and no memory activity (latency 1 cycle).

Decomposition:
- Shared package mau_pkg holds:
  - op encodings: OP_LOAD=2'b00, OP_STORE=2'b01, OP_LOAD_IND=2'b10, OP_STORE_IND=2'b11
  - state enum: IDLE, PTR, ACCESS, RESP
  - default widths
- No sub-module is warranted: FSM, datapath latches and bounds compare fit in one module.
- The bench instantiates this unit together with the existing data memory.

Test Plan:
- STORE addr=5 wdata=32'hDEADBEEF, then LOAD addr=5 -> mem_write high for exactly one cycle with address 5; LOAD resp_valid 2 cycles after accept, resp_data=32'hDEADBEEF, resp_fault=0.
- Preload mem[10]=20 and mem[20]=32'h1234; LOAD_IND addr=10 -> PTR mem_address=10, then ACCESS mem_address=20; resp_data=32'h1234 at 3-cycle latency. STORE_IND addr=10 wdata=7 -> mem[20]=7.
- LOAD addr=1024 and STORE addr=32'hFFFFFFFF -> resp_fault=1, resp_data=0, mem_read and mem_write never asserted. LOAD_IND with mem[10]=2000 -> fault raised in ACCESS with no second mem_read.
- Hold resp_ready=0 for 5 cycles during a LOAD of addr=3 -> resp_valid and resp_data stable throughout, req_ready=0, new req_valid ignored; resp_ready=1 -> IDLE next cycle.
- Drop rst_n during the ACCESS cycle of STORE addr=8 wdata=99 -> mem_write falls immediately, mem[8] unchanged, all outputs at reset values, first request after release completes normally.
- Without MAU_INDIRECT_EN: LOAD_IND addr=10 -> resp_fault=1 one cycle after accept, no memory activity.

Source files
------------

// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit: op encodings, FSM states, default widths.
package mau_pkg;

  localparam int unsigned DefAddrW   = 32;
  localparam int unsigned DefDataW   = 32;
  localparam int unsigned DefMemDepth = 1024;

  localparam logic [1:0] OP_LOAD      = 2'b00;
  localparam logic [1:0] OP_STORE     = 2'b01;
  localparam logic [1:0] OP_LOAD_IND  = 2'b10;
  localparam logic [1:0] OP_STORE_IND = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StPtr,
    StAccess,
    StResp
  } mau_state_e;

  // Bit 1 of the op selects indirection, bit 0 selects store.
  function automatic logic op_is_ind(logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_store(logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/mem_access_unit.sv
// Load/store initiator on the data-memory port with LC-3 style indirect accesses and bounds check.
// Optional: define MAU_INDIRECT_EN to build the pointer phase; otherwise *_IND ops fault at once.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned MEM_DEPTH = DefMemDepth
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_fault,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  // One extra bit so MEM_DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DepthExt = (ADDR_W + 1)'(MEM_DEPTH);

  function automatic logic in_range(logic [ADDR_W-1:0] a);
    return {1'b0, a} < DepthExt;
  endfunction

  mau_state_e        state_q, state_d;
  logic              store_q, store_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              fault_q, fault_d;
  logic [ADDR_W-1:0] eff_addr;

`ifdef MAU_INDIRECT_EN
  logic              ind_q, ind_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  assign eff_addr = ind_q ? ptr_q : addr_q;
`else
  assign eff_addr = addr_q;
`endif

  assign req_ready  = rst_n && (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_data  = rdata_q;
  assign resp_fault = fault_q;

  always_comb begin
    state_d        = state_q;
    store_d        = store_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    fault_d        = fault_q;
`ifdef MAU_INDIRECT_EN
    ind_d          = ind_q;
    ptr_d          = ptr_q;
`endif
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          store_d = op_is_store(req_op);
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          fault_d = 1'b0;
`ifdef MAU_INDIRECT_EN
          ind_d   = op_is_ind(req_op);
          state_d = op_is_ind(req_op) ? StPtr : StAccess;
`else
          if (op_is_ind(req_op)) begin
            fault_d = 1'b1;
            state_d = StResp;
          end else begin
            state_d = StAccess;
          end
`endif
        end
      end

`ifdef MAU_INDIRECT_EN
      StPtr: begin
        if (!in_range(addr_q)) begin
          fault_d = 1'b1;
          state_d = StResp;
        end else begin
          mem_read    = 1'b1;
          mem_address = addr_q;
          ptr_d       = ADDR_W'(mem_read_data);
          state_d     = StAccess;
        end
      end
`endif

      StAccess: begin
        state_d = StResp;
        if (!in_range(eff_addr)) begin
          fault_d = 1'b1;
        end else if (store_q) begin
          mem_write      = 1'b1;
          mem_address    = eff_addr;
          mem_write_data = wdata_q;
        end else begin
          mem_read    = 1'b1;
          mem_address = eff_addr;
          rdata_d     = mem_read_data;
        end
      end

      StResp: begin
        if (resp_ready) begin
          rdata_d = '0;
          fault_d = 1'b0;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      store_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
`ifdef MAU_INDIRECT_EN
      ind_q   <= 1'b0;
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
`ifdef MAU_INDIRECT_EN
      ind_q   <= ind_d;
      ptr_q   <= ptr_d;
`endif
    end
  end

endmodule
